// File: rtl/load_store_unit_pkg.sv
// Shared types for the load/store unit: funct3 codes, FSM states,
// lane constants and the fault-decode helper.
package lsu_pkg;

  typedef enum logic [2:0] {
    F3_B  = 3'b000,
    F3_H  = 3'b001,
    F3_W  = 3'b010,
    F3_BU = 3'b100,
    F3_HU = 3'b101
  } funct3_e;

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    RSP,
    DONE,
    FAULT
  } lsu_state_t;

  localparam logic [3:0] WSTRB_NONE = 4'b0000;

  // Illegal width code or address not aligned to the access size.
  function automatic logic op_fault(
    input logic       st,
    input logic [2:0] f3,
    input logic [1:0] off
  );
    logic bad_f3;
    logic mis;
    bad_f3 = st ? (f3 > F3_W)
                : ((f3 == 3'b011) || (f3 > F3_HU));
    mis = ((f3[1:0] == 2'b01) && off[0]) ||
          ((f3[1:0] == 2'b10) && (off != 2'b00));
    return bad_f3 || mis;
  endfunction

endpackage

// File: rtl/load_store_unit_if.sv
// Data-memory bus: valid/ready request channel plus a valid-only
// response channel. master = LSU side, slave = memory side.
interface load_store_unit_if;
  logic        mem_req_valid;
  logic        mem_req_ready;
  logic [31:0] mem_addr;
  logic        mem_we;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_wdata;
  logic        mem_rsp_valid;
  logic [31:0] mem_rdata;

  modport master (
    output mem_req_valid, mem_addr, mem_we,
    output mem_wstrb, mem_wdata,
    input  mem_req_ready, mem_rsp_valid, mem_rdata
  );

  modport slave (
    input  mem_req_valid, mem_addr, mem_we,
    input  mem_wstrb, mem_wdata,
    output mem_req_ready, mem_rsp_valid, mem_rdata
  );
endinterface

// File: rtl/load_store_unit_load_extend.sv
// Load extraction: picks byte/half by byte_off and sign/zero extends.
// In: rdata, byte_off, funct3. Out: ext (32-bit write-back value).
module load_extend
  import lsu_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  byte_off,
  input  logic [2:0]  funct3,
  output logic [31:0] ext
);

  logic [7:0]  b;
  logic [15:0] h;

  assign b = rdata[{byte_off, 3'b000} +: 8];
  assign h = byte_off[1] ? rdata[31:16] : rdata[15:0];

  always_comb begin
    ext = rdata;
    unique case (1'b1)
      funct3 == F3_B:  ext = {{24{b[7]}}, b};
      funct3 == F3_H:  ext = {{16{h[15]}}, h};
      funct3 == F3_BU: ext = {24'h0, b};
      funct3 == F3_HU: ext = {16'h0, h};
      default:         ext = rdata;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// RV32I load/store stage: one memory op per start, busy while active.
// Ports: clk/reset_n, core op inputs, busy/done/fault/load_data, mem bus.
module load_store_unit
  import lsu_pkg::*;
(
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic        is_store,
  input  logic [2:0]  funct3,
  input  logic [31:0] addr,
  input  logic [31:0] store_data,
  output logic        busy,
  output logic        done,
  output logic        fault,
  output logic [31:0] load_data,
  load_store_unit_if.master mem
);

  lsu_state_t  state_q, state_d;
  logic        st_q;
  logic [2:0]  f3_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q, wdata_d;
  logic [3:0]  wstrb_q, wstrb_d;
  logic [31:0] ld_q;
  logic [31:0] ext;
  logic        take;

  assign take = (state_q == IDLE) && start;

  // Store lanes are formed at capture so the bus holds flops only.
  always_comb begin
    wdata_d = store_data;
    wstrb_d = 4'b1111;
    unique case (1'b1)
      funct3[1:0] == 2'b00: begin
        wdata_d = {4{store_data[7:0]}};
        wstrb_d = 4'b0001 << addr[1:0];
      end
      funct3[1:0] == 2'b01: begin
        wdata_d = {2{store_data[15:0]}};
        wstrb_d = 4'b0011 << addr[1:0];
      end
      default: ;
    endcase
    if (!is_store) wstrb_d = WSTRB_NONE;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (start)
        state_d = op_fault(is_store, funct3, addr[1:0])
                  ? FAULT : REQ;
      REQ: if (mem.mem_req_ready)
        state_d = st_q ? DONE : RSP;
      RSP: if (mem.mem_rsp_valid)
        state_d = DONE;
      DONE:    state_d = IDLE;
      FAULT:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      st_q    <= 1'b0;
      f3_q    <= 3'b000;
      addr_q  <= 32'h0;
      wdata_q <= 32'h0;
      wstrb_q <= WSTRB_NONE;
      ld_q    <= 32'h0;
    end else begin
      if (take) begin
        st_q    <= is_store;
        f3_q    <= funct3;
        addr_q  <= addr;
        wdata_q <= wdata_d;
        wstrb_q <= wstrb_d;
      end
      if (state_q == RSP && mem.mem_rsp_valid)
        ld_q <= ext;
    end
  end

  load_extend u_ext (
    .rdata    (mem.mem_rdata),
    .byte_off (addr_q[1:0]),
    .funct3   (f3_q),
    .ext      (ext)
  );

  assign busy      = (state_q != IDLE);
  assign done      = (state_q == DONE) || (state_q == FAULT);
  assign fault     = (state_q == FAULT);
  assign load_data = ld_q;

  assign mem.mem_req_valid = (state_q == REQ);
  assign mem.mem_addr      = {addr_q[31:2], 2'b00};
  assign mem.mem_we        = (state_q == REQ) && st_q;
  assign mem.mem_wstrb     = wstrb_q;
  assign mem.mem_wdata     = wdata_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: byte-level memory reference model,
// request/response scoreboards, random waits and random ops.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0;
  logic        is_store = 1'b0;
  logic [2:0]  funct3 = 3'b000;
  logic [31:0] addr = 32'h0;
  logic [31:0] store_data = 32'h0;
  logic        busy, done, fault;
  logic [31:0] load_data;

  load_store_unit_if mem ();

  always #5 clk = ~clk;

  load_store_unit dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .start      (start),
    .is_store   (is_store),
    .funct3     (funct3),
    .addr       (addr),
    .store_data (store_data),
    .busy       (busy),
    .done       (done),
    .fault      (fault),
    .load_data  (load_data),
    .mem        (mem.master)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  typedef struct {
    logic [31:0] addr;
    logic        we;
    logic [3:0]  wstrb;
    logic [31:0] wdata;
  } req_t;

  typedef struct {
    logic        fault;
    logic [31:0] data;
  } rsp_t;

  req_t exp_req[$];
  rsp_t exp_rsp[$];

  logic [7:0]  ref_bytes [int unsigned];
  logic [31:0] mem_words [int unsigned];
  logic [31:0] last_load = 32'h0;
  int          req_wait = 0;
  int          rsp_wait = 0;

  function automatic logic [31:0] init_word(input logic [31:0] wa);
    return (wa * 32'h9E3779B1) ^ 32'h5A5A0F0F;
  endfunction

  function automatic logic [7:0] ref_rd(input logic [31:0] a);
    logic [31:0] w;
    if (ref_bytes.exists(a)) return ref_bytes[a];
    w = init_word(a & ~32'h3);
    return w[8*a[1:0] +: 8];
  endfunction

  function automatic logic [31:0] mem_rd(input logic [31:0] wa);
    if (mem_words.exists(wa)) return mem_words[wa];
    return init_word(wa);
  endfunction

  task automatic preload(input logic [31:0] wa, input logic [31:0] v);
    mem_words[wa] = v;
    for (int i = 0; i < 4; i++) ref_bytes[wa + i] = v[8*i +: 8];
  endtask

  // Issue one op, update the reference model, wait for done.
  task automatic do_op(input bit st, input logic [2:0] f3,
                       input logic [31:0] a, input logic [31:0] sd,
                       input int rw, input int sw, input bit hold);
    int   size, exp_lat, lat;
    bit   bad, is_f, got;
    req_t rq;
    rsp_t rs;
    logic [31:0] val, m;
    size = (f3[1:0] == 2'b00) ? 1 : (f3[1:0] == 2'b01) ? 2 : 4;
    bad  = st ? (f3 > 3'd2) : (f3 == 3'd3 || f3 > 3'd5);
    is_f = bad || ((int'(a[1:0]) % size) != 0);
    @(negedge clk);
    start = 1'b1; is_store = st; funct3 = f3;
    addr = a; store_data = sd;
    req_wait = rw; rsp_wait = sw;
    if (!is_f) begin
      rq.addr = a & ~32'h3;
      rq.we = st;
      rq.wstrb = 4'b0000;
      rq.wdata = 32'h0;
      if (st) begin
        rq.wstrb = 4'(((1 << size) - 1) << a[1:0]);
        for (int i = 0; i < 4; i++)
          rq.wdata[8*i +: 8] = sd[8*(i % size) +: 8];
        for (int i = 0; i < size; i++)
          ref_bytes[a + i] = sd[8*i +: 8];
      end else begin
        val = 32'h0;
        for (int i = 0; i < size; i++)
          val[8*i +: 8] = ref_rd(a + i);
        if (!f3[2] && size < 4 && val[8*size-1]) begin
          m = (32'h1 << (8*size)) - 32'h1;
          val = val | ~m;
        end
        last_load = val;
      end
      exp_req.push_back(rq);
    end
    rs.fault = is_f;
    rs.data = last_load;
    exp_rsp.push_back(rs);
    exp_lat = is_f ? 1 : (st ? 2 + rw : 3 + rw + sw);
    @(posedge clk);
    lat = 0;
    got = 0;
    while (!got && lat < 60) begin
      @(negedge clk);
      lat++;
      if (!hold) start = 1'b0;
      is_store = 1'($urandom);
      funct3 = 3'($urandom);
      addr = $urandom;
      store_data = $urandom;
      check("busy", {31'h0, busy}, 32'h1);
      if (done) got = 1;
    end
    start = 1'b0;
    if (!got) check("done_timeout", 32'h0, 32'h1);
    else check("latency", 32'(lat), 32'(exp_lat));
  endtask

  // Scoreboard monitor for completions.
  always @(negedge clk) begin : mon
    rsp_t r;
    if (reset_n && done) begin
      if (exp_rsp.size() == 0) begin
        check("done_unexpected", 32'h1, 32'h0);
      end else begin
        r = exp_rsp.pop_front();
        check("fault", {31'h0, fault}, {31'h0, r.fault});
        check("load_data", load_data, r.data);
      end
    end
  end

  // Memory model with programmable request/response waits.
  initial begin : resp
    int   rcnt, scnt;
    bit   in_rsp, hs;
    logic [31:0] acc_addr, acc_wdata, w;
    logic        acc_we;
    logic [3:0]  acc_wstrb;
    req_t e;
    rcnt = 0; scnt = 0; in_rsp = 0; hs = 0;
    acc_addr = 0; acc_wdata = 0; acc_we = 0; acc_wstrb = 0;
    mem.mem_req_ready = 1'b0;
    mem.mem_rsp_valid = 1'b0;
    mem.mem_rdata = 32'h0;
    forever begin
      @(negedge clk);
      if (!reset_n) begin
        rcnt = 0; scnt = 0; in_rsp = 0; hs = 0;
        mem.mem_req_ready = 1'b0;
        mem.mem_rsp_valid = 1'b0;
        continue;
      end
      if (hs) begin
        if (exp_req.size() > 0) void'(exp_req.pop_front());
        if (acc_we) begin
          w = mem_rd(acc_addr);
          for (int i = 0; i < 4; i++)
            if (acc_wstrb[i]) w[8*i +: 8] = acc_wdata[8*i +: 8];
          mem_words[acc_addr] = w;
        end else begin
          in_rsp = 1;
          scnt = 0;
        end
      end
      mem.mem_req_ready = 1'b0;
      mem.mem_rsp_valid = 1'b0;
      mem.mem_rdata = $urandom;
      if (in_rsp) begin
        if (scnt < rsp_wait) scnt++;
        else begin
          mem.mem_rsp_valid = 1'b1;
          mem.mem_rdata = mem_rd(acc_addr);
          in_rsp = 0;
        end
      end else if (mem.mem_req_valid) begin
        if (exp_req.size() == 0) begin
          check("req_unexpected", 32'h1, 32'h0);
        end else begin
          e = exp_req[0];
          check("req_addr", mem.mem_addr, e.addr);
          check("req_we", {31'h0, mem.mem_we}, {31'h0, e.we});
          check("req_wstrb", {28'h0, mem.mem_wstrb}, {28'h0, e.wstrb});
          if (e.we) check("req_wdata", mem.mem_wdata, e.wdata);
        end
        if (rcnt < req_wait) begin
          rcnt++;
          mem.mem_rsp_valid = 1'($urandom);
        end else begin
          mem.mem_req_ready = 1'b1;
          rcnt = 0;
          acc_addr = mem.mem_addr;
          acc_we = mem.mem_we;
          acc_wstrb = mem.mem_wstrb;
          acc_wdata = mem.mem_wdata;
        end
      end else begin
        mem.mem_rsp_valid = ($urandom_range(0, 3) == 0);
      end
      hs = mem.mem_req_valid && mem.mem_req_ready;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    req_t rq;
    repeat (2) @(negedge clk);
    check("rst_busy", {31'h0, busy}, 32'h0);
    check("rst_done", {30'h0, done, fault}, 32'h0);
    check("rst_req", {30'h0, mem.mem_req_valid, mem.mem_we}, 32'h0);
    check("rst_wstrb", {28'h0, mem.mem_wstrb}, 32'h0);
    check("rst_addr", mem.mem_addr, 32'h0);
    check("rst_wdata", mem.mem_wdata, 32'h0);
    check("rst_load", load_data, 32'h0);
    reset_n = 1'b1;

    preload(32'h1000, 32'h80FFFF7F);
    do_op(0, 3'b000, 32'h1003, 32'h0, 0, 0, 0);
    check("lb_value", load_data, 32'hFFFFFF80);
    preload(32'h2000, 32'hBEEF1234);
    do_op(0, 3'b101, 32'h2002, 32'h0, 0, 0, 0);
    check("lhu_value", load_data, 32'h0000BEEF);
    do_op(1, 3'b000, 32'h11, 32'hAB, 3, 0, 0);
    do_op(0, 3'b010, 32'h6, 32'h0, 0, 0, 0);
    do_op(0, 3'b011, 32'h8, 32'h0, 0, 0, 0);
    do_op(1, 3'b001, 32'h13, 32'h5555, 0, 0, 0);

    // Reset while a request is stalled.
    @(negedge clk);
    start = 1'b1; is_store = 1'b0;
    funct3 = 3'b010; addr = 32'h300;
    req_wait = 5;
    rq.addr = 32'h300; rq.we = 1'b0;
    rq.wstrb = 4'b0000; rq.wdata = 32'h0;
    exp_req.push_back(rq);
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    check("rst_mid_pre", {31'h0, mem.mem_req_valid}, 32'h1);
    #2 reset_n = 1'b0;
    #1;
    check("rst_mid_valid", {31'h0, mem.mem_req_valid}, 32'h0);
    check("rst_mid_busy", {31'h0, busy}, 32'h0);
    exp_req.delete();
    exp_rsp.delete();
    last_load = 32'h0;
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    do_op(0, 3'b010, 32'h1000, 32'h0, 0, 0, 0);
    check("lw_after_rst", load_data, 32'h80FFFF7F);

    do_op(1, 3'b010, 32'h40, 32'hDEADBEEF, 0, 0, 0);
    do_op(0, 3'b010, 32'h40, 32'h0, 0, 0, 1);
    check("b2b_lw", load_data, 32'hDEADBEEF);
    repeat (3) @(negedge clk);
    check("b2b_idle", {31'h0, busy}, 32'h0);

    for (int k = 0; k < 60; k++)
      do_op(1'($urandom), 3'($urandom),
            32'h100 + $urandom_range(0, 31), $urandom,
            $urandom_range(0, 3), $urandom_range(0, 3),
            1'($urandom));

    repeat (4) @(negedge clk);
    check("rsp_left", 32'(exp_rsp.size()), 32'h0);
    check("req_left", 32'(exp_req.size()), 32'h0);
    $display("Simulation finished: %0d checks, %0d errors",
             n_checks, n_errors);
    $finish;
  end

endmodule
